// File: rtl/ss2_bridge_pkg.sv
// Shared types and constants for the SimpleSerial2 multi-target bridge.
package ss2_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam int          STATUS_OFF_FLAGS = 0;
  localparam int          STATUS_OFF_TMO   = 1;
  localparam logic [7:0]  ERR_BYTE_DEFAULT = 8'hEE;

  // Select value reserved for the bridge's own status registers.
  function automatic int status_sel(input int sel_bits);
    return (1 << sel_bits) - 1;
  endfunction

endpackage

// File: rtl/ss2_strobe_edge.sv
// Registers the combined ss2 strobe through two flops and flags its rising edge.
module ss2_strobe_edge (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = strobe;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign rise = s1_q & ~s2_q;

endmodule

// File: rtl/ss2_multi_target_bridge.sv
// Bridges the ss2 byte bus to several req/ack register targets, with timeout,
// unmapped-select handling and a small status block at the all-ones select.
module ss2_multi_target_bridge
  import ss2_bridge_pkg::*;
#(
  parameter int         pADDR_WIDTH  = 32,
  parameter int         pNUM_TARGETS = 4,
  parameter int         pSEL_BITS    = 4,
  parameter int         pTIMEOUT     = 1023,
  parameter logic [7:0] pERR_BYTE    = ERR_BYTE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [pADDR_WIDTH-1:0]        up_addr,
  input  logic [7:0]                    up_wdata,
  input  logic                          up_rdn,
  input  logic                          up_wrn,
  input  logic                          up_cen,
  output logic [7:0]                    up_rdata,
  output logic                          up_busy,
  output logic [pNUM_TARGETS-1:0]       tgt_req,
  output logic                          tgt_we,
  output logic [pADDR_WIDTH-pSEL_BITS-1:0] tgt_addr,
  output logic [7:0]                    tgt_wdata,
  input  logic [8*pNUM_TARGETS-1:0]     tgt_rdata,
  input  logic [pNUM_TARGETS-1:0]       tgt_ack,
  output logic                          err_timeout
);

  localparam int OFF_W = pADDR_WIDTH - pSEL_BITS;
  localparam int CNT_W = $clog2(pTIMEOUT + 1);
  localparam logic [pSEL_BITS-1:0] STATUS_SEL = pSEL_BITS'(status_sel(pSEL_BITS));
  localparam logic [pSEL_BITS-1:0] NUM_T      = pSEL_BITS'(pNUM_TARGETS);
  localparam logic [CNT_W-1:0]     TMO_LAST   = CNT_W'(pTIMEOUT - 1);
  localparam logic [OFF_W-1:0]     OFF_FLAGS  = OFF_W'(STATUS_OFF_FLAGS);
  localparam logic [OFF_W-1:0]     OFF_TMO    = OFF_W'(STATUS_OFF_TMO);

  state_e               state_q, state_d;
  logic [pSEL_BITS-1:0] sel_q, sel_d;
  logic                 we_q, we_d;
  logic [OFF_W-1:0]     addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 err_unmapped_q, err_unmapped_d;
  logic [7:0]           tmo_cnt_q, tmo_cnt_d;

  logic                    strobe;
  logic                    rise;
  logic                    start;
  logic [pSEL_BITS-1:0]    up_sel;
  logic [OFF_W-1:0]        up_off;
  logic                    up_we;
  logic [7:0]              status_rd;
  logic [pNUM_TARGETS-1:0] sel_onehot;
  logic [7:0]              rd_terms [pNUM_TARGETS];
  logic [7:0]              sel_rdata;
  logic                    ack_hit;

  assign strobe = ~up_cen & (~up_rdn | ~up_wrn);

  ss2_strobe_edge u_strobe_edge (
    .clk    (clk),
    .reset  (reset),
    .strobe (strobe),
    .rise   (rise)
  );

  // An edge that lands while busy (including the trailing busy cycle) is dropped.
  assign start  = rise & ~busy_q & (state_q == IDLE);
  assign up_sel = up_addr[pADDR_WIDTH-1 -: pSEL_BITS];
  assign up_off = up_addr[OFF_W-1:0];
  assign up_we  = ~up_wrn;

  generate
    for (genvar gi = 0; gi < pNUM_TARGETS; gi++) begin : g_tgt
      assign sel_onehot[gi] = (sel_q == pSEL_BITS'(gi));
      assign rd_terms[gi]   = tgt_rdata[8*gi +: 8] & {8{sel_onehot[gi]}};
    end
  endgenerate

  always_comb begin
    sel_rdata = 8'h00;
    for (int i = 0; i < pNUM_TARGETS; i++) begin
      sel_rdata = sel_rdata | rd_terms[i];
    end
  end

  assign ack_hit = |(tgt_ack & sel_onehot);

  always_comb begin
    status_rd = 8'h00;
    if (up_off == OFF_FLAGS) begin
      status_rd = {6'b0, err_unmapped_q, err_timeout_q};
    end else if (up_off == OFF_TMO) begin
      status_rd = tmo_cnt_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    busy_d         = busy_q;
    cnt_d          = cnt_q;
    err_timeout_d  = err_timeout_q;
    err_unmapped_d = err_unmapped_q;
    tmo_cnt_d      = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        busy_d = start;
        if (start) begin
          sel_d   = up_sel;
          we_d    = up_we;
          addr_d  = up_off;
          wdata_d = up_wdata;
          cnt_d   = '0;
          if (up_sel == STATUS_SEL) begin
            state_d = DONE;
            if (up_we) begin
              if (up_off == OFF_FLAGS) begin
                err_timeout_d  = 1'b0;
                err_unmapped_d = 1'b0;
                tmo_cnt_d      = 8'h00;
              end
            end else begin
              rdata_d = status_rd;
            end
          end else if (up_sel < NUM_T) begin
            state_d = REQ;
          end else begin
            state_d        = DONE;
            err_unmapped_d = 1'b1;
            if (!up_we) begin
              rdata_d = pERR_BYTE;
            end
          end
        end
      end
      REQ: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        // A late ack in the final cycle still counts as success.
        if (ack_hit) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = sel_rdata;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d       = ERR;
          rdata_d       = pERR_BYTE;
          err_timeout_d = 1'b1;
          if (tmo_cnt_q != 8'hFF) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
          end
        end
      end
      DONE, ERR: begin
        busy_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= 8'h00;
      rdata_q        <= 8'h00;
      busy_q         <= 1'b0;
      cnt_q          <= '0;
      err_timeout_q  <= 1'b0;
      err_unmapped_q <= 1'b0;
      tmo_cnt_q      <= 8'h00;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
      busy_q         <= busy_d;
      cnt_q          <= cnt_d;
      err_timeout_q  <= err_timeout_d;
      err_unmapped_q <= err_unmapped_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  // Request is decoded from registered state so reset removes it without waiting for a clock.
  assign tgt_req     = (state_q == REQ) ? sel_onehot : '0;
  assign tgt_we      = we_q;
  assign tgt_addr    = addr_q;
  assign tgt_wdata   = wdata_q;
  assign up_rdata    = rdata_q;
  assign up_busy     = busy_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ss2_multi_target_bridge.sv
// Scoreboard bench: stimulus pushes expected transaction results, a negedge monitor checks them.
module tb_ss2_multi_target_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] up_addr = '0;
  logic [7:0]  up_wdata = '0;
  logic        up_rdn = 1'b1;
  logic        up_wrn = 1'b1;
  logic        up_cen = 1'b1;
  logic [7:0]  up_rdata;
  logic        up_busy;
  logic [3:0]  tgt_req;
  logic        tgt_we;
  logic [27:0] tgt_addr;
  logic [7:0]  tgt_wdata;
  logic [31:0] tgt_rdata = '0;
  logic [3:0]  tgt_ack = '0;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ss2_multi_target_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .up_addr     (up_addr),
    .up_wdata    (up_wdata),
    .up_rdn      (up_rdn),
    .up_wrn      (up_wrn),
    .up_cen      (up_cen),
    .up_rdata    (up_rdata),
    .up_busy     (up_busy),
    .tgt_req     (tgt_req),
    .tgt_we      (tgt_we),
    .tgt_addr    (tgt_addr),
    .tgt_wdata   (tgt_wdata),
    .tgt_rdata   (tgt_rdata),
    .tgt_ack     (tgt_ack),
    .err_timeout (err_timeout)
  );

  typedef struct {
    logic        chk_rd;
    logic [7:0]  rd;
    int          busy;
    logic [3:0]  mask;
    int          pulses;
    int          req_cyc;
    logic        we;
    logic [27:0] addr;
    logic [7:0]  wd;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic chk_rd, input logic [7:0] rd, input int busy,
                              input logic [3:0] mask, input int pulses, input int req_cyc,
                              input logic we, input logic [27:0] addr, input logic [7:0] wd);
    exp_t e;
    e.chk_rd = chk_rd; e.rd = rd; e.busy = busy; e.mask = mask; e.pulses = pulses;
    e.req_cyc = req_cyc; e.we = we; e.addr = addr; e.wd = wd;
    return e;
  endfunction

  // Monitor: track one busy window, compare against the scoreboard when busy falls.
  logic        in_txn = 1'b0;
  int          blen, pulses, rcyc;
  logic [3:0]  mask, prev_req;
  logic        cap_we;
  logic [27:0] cap_addr;
  logic [7:0]  cap_wd;

  always @(negedge clk) begin
    if (reset) begin
      in_txn   = 1'b0;
      prev_req = '0;
    end else if (up_busy) begin
      if (!in_txn) begin
        in_txn = 1'b1; blen = 0; pulses = 0; rcyc = 0; mask = '0; prev_req = '0;
        cap_we = 1'b0; cap_addr = '0; cap_wd = '0;
      end
      blen++;
      if (tgt_req != 4'b0) begin
        rcyc++;
        mask = mask | tgt_req;
        if (prev_req == 4'b0) begin
          pulses++;
          cap_we = tgt_we; cap_addr = tgt_addr; cap_wd = tgt_wdata;
        end
      end
      prev_req = tgt_req;
    end else if (in_txn) begin
      in_txn = 1'b0;
      if (sb.size() == 0) begin
        check("unexpected_txn", 32'(blen), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("busy_len", 32'(blen), 32'(e.busy));
        check("req_mask", 32'(mask), 32'(e.mask));
        check("req_pulses", 32'(pulses), 32'(e.pulses));
        check("req_cycles", 32'(rcyc), 32'(e.req_cyc));
        if (e.chk_rd) check("up_rdata", 32'(up_rdata), 32'(e.rd));
        if (e.mask != 4'b0) begin
          check("tgt_we", 32'(cap_we), 32'(e.we));
          check("tgt_addr", 32'(cap_addr), 32'(e.addr));
          if (e.we) check("tgt_wdata", 32'(cap_wd), 32'(e.wd));
        end
        $display("txn done: busy=%0d req=%b pulses=%0d rdata=0x%02h", blen, mask, pulses, up_rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_strobe();
    up_cen = 1'b1; up_rdn = 1'b1; up_wrn = 1'b1;
  endtask

  task automatic assert_strobe(input logic [3:0] sel, input logic [27:0] off,
                               input logic wr, input logic [7:0] wd);
    up_addr = {sel, off}; up_wdata = wd; up_cen = 1'b0;
    if (wr) up_wrn = 1'b0; else up_rdn = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (up_busy && n < limit) begin
      tick();
      n++;
    end
    if (up_busy) check("busy_timeout", 32'(up_busy), 32'd0);
    repeat (3) tick();
  endtask

  // ack_cyc: REQ cycle (1 = first) in which ack_tgt pulses; 0 = never.
  task automatic txn(input logic [3:0] sel, input logic [27:0] off, input logic wr,
                     input logic [7:0] wd, input int ack_tgt, input int ack_cyc,
                     input logic [7:0] ack_rd, input exp_t e);
    sb.push_back(e);
    assert_strobe(sel, off, wr, wd);
    tick(); tick();
    release_strobe();
    if (ack_cyc > 0) begin
      for (int i = 1; i < ack_cyc; i++) tick();
      tgt_rdata[8*ack_tgt +: 8] = ack_rd;
      tgt_ack[ack_tgt] = 1'b1;
      tick();
      tgt_ack = '0;
    end
    wait_idle(2000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_req", 32'(tgt_req), 32'd0);
    check("rst_busy", 32'(up_busy), 32'd0);
    check("rst_rdata", 32'(up_rdata), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // 1: write tgt 2, ack on 4th REQ cycle
    txn(4'h2, 28'h10, 1'b1, 8'h5A, 2, 4, 8'h00,
        mk(1'b0, 8'h00, 6, 4'b0100, 1, 4, 1'b1, 28'h10, 8'h5A));
    // 2: read tgt 0, ack on first REQ cycle
    txn(4'h0, 28'h3, 1'b0, 8'h00, 0, 1, 8'h3C,
        mk(1'b1, 8'h3C, 3, 4'b0001, 1, 1, 1'b0, 28'h3, 8'h00));
    // 3: read tgt 1, no ack -> timeout
    txn(4'h1, 28'h44, 1'b0, 8'h00, 0, 0, 8'h00,
        mk(1'b1, 8'hEE, 1025, 4'b0010, 1, 1023, 1'b0, 28'h44, 8'h00));
    check("err_timeout_set", 32'(err_timeout), 32'd1);
    txn(4'hF, 28'h1, 1'b0, 8'h00, 0, 0, 8'h00,
        mk(1'b1, 8'h01, 2, 4'b0, 0, 0, 1'b0, 28'h0, 8'h00));
    txn(4'hF, 28'h0, 1'b0, 8'h00, 0, 0, 8'h00,
        mk(1'b1, 8'h01, 2, 4'b0, 0, 0, 1'b0, 28'h0, 8'h00));
    txn(4'hF, 28'h0, 1'b1, 8'h00, 0, 0, 8'h00,
        mk(1'b0, 8'h00, 2, 4'b0, 0, 0, 1'b0, 28'h0, 8'h00));
    check("err_timeout_clr", 32'(err_timeout), 32'd0);
    txn(4'hF, 28'h1, 1'b0, 8'h00, 0, 0, 8'h00,
        mk(1'b1, 8'h00, 2, 4'b0, 0, 0, 1'b0, 28'h0, 8'h00));

    // 4: unmapped select
    txn(4'h5, 28'h7, 1'b0, 8'h00, 0, 0, 8'h00,
        mk(1'b1, 8'hEE, 2, 4'b0, 0, 0, 1'b0, 28'h0, 8'h00));
    txn(4'h9, 28'h7, 1'b1, 8'h12, 0, 0, 8'h00,
        mk(1'b0, 8'h00, 2, 4'b0, 0, 0, 1'b0, 28'h0, 8'h00));
    txn(4'hF, 28'h0, 1'b0, 8'h00, 0, 0, 8'h00,
        mk(1'b1, 8'h02, 2, 4'b0, 0, 0, 1'b0, 28'h0, 8'h00));
    txn(4'hF, 28'h0, 1'b1, 8'h00, 0, 0, 8'h00,
        mk(1'b0, 8'h00, 2, 4'b0, 0, 0, 1'b0, 28'h0, 8'h00));
    txn(4'hF, 28'h0, 1'b0, 8'h00, 0, 0, 8'h00,
        mk(1'b1, 8'h00, 2, 4'b0, 0, 0, 1'b0, 28'h0, 8'h00));

    // 5: strobe held 50 cycles with a re-edge mid-busy; stray ack from tgt 3
    sb.push_back(mk(1'b1, 8'h77, 12, 4'b0010, 1, 10, 1'b0, 28'h20, 8'h00));
    tgt_rdata[31:24] = 8'h99;
    assert_strobe(4'h1, 28'h20, 1'b0, 8'h00);
    tick(); tick();
    for (int c = 1; c <= 48; c++) begin
      if (c == 3)  tgt_ack = 4'b1000;
      if (c == 4)  tgt_ack = 4'b0000;
      if (c == 5)  release_strobe();
      if (c == 6)  assert_strobe(4'h1, 28'h20, 1'b0, 8'h00);
      if (c == 10) begin tgt_rdata[15:8] = 8'h77; tgt_ack = 4'b0010; end
      if (c == 11) tgt_ack = 4'b0000;
      tick();
    end
    release_strobe();
    wait_idle(100);

    // 6: reset while REQ active, then a normal read
    assert_strobe(4'h0, 28'h8, 1'b0, 8'h00);
    tick(); tick();
    tick();
    check("pre_rst_req", 32'(tgt_req), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(tgt_req), 32'd0);
    check("mid_rst_busy", 32'(up_busy), 32'd0);
    release_strobe();
    tick();
    reset = 1'b0;
    repeat (2) tick();
    txn(4'h0, 28'h8, 1'b0, 8'h00, 0, 2, 8'hA5,
        mk(1'b1, 8'hA5, 4, 4'b0001, 1, 2, 1'b0, 28'h8, 8'h00));

    repeat (5) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
